// File: rtl/stack_pkg.sv
// Shared helpers for frame stacks: count sizing, the zero-frame fill bit and
// the per-cycle operation encoding used by frame_stack.
package stack_pkg;

  // Bits needed to hold an occupancy count from 0 to depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Replicated to DATA_WIDTH wherever an empty slot has to read as a zero frame.
  localparam logic FRAME_ZERO_BIT = 1'b0;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_CLEAR
  } stack_op_e;

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x DATA_WIDTH frame storage with one write port and two asynchronous
// read ports. It is built from LUT RAM or flops, so a read has no latency.
module stack_regfile #(
  parameter int DEPTH      = 20,
  parameter int DATA_WIDTH = 128,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr0,
  input  logic [AW-1:0]         i_raddr1,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  output logic [DATA_WIDTH-1:0] o_rdata1
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // The contents are deliberately not reset. The stack count defines which entries are valid.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/frame_stack.sv
// LIFO of opaque frames with replace-top, registered top/second views, flush,
// sticky overflow/underflow flags and an occupancy high-water mark.
module frame_stack
  import stack_pkg::*;
#(
  parameter int DEPTH      = 20,
  parameter int DATA_WIDTH = 128,
  parameter int CW         = count_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] top_data,
  output logic [DATA_WIDTH-1:0] second_data,
  output logic                  empty,
  output logic                  full,
  output logic [CW-1:0]         count,
  output logic [CW-1:0]         max_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] ZERO_FRAME = {DATA_WIDTH{FRAME_ZERO_BIT}};

  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_max_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_overflow;
  logic                  r_underflow;
  logic [DATA_WIDTH-1:0] r_top;
  logic [DATA_WIDTH-1:0] r_second;

  stack_op_e             w_op;
  logic [CW-1:0]         w_count_next;
  logic [CW-1:0]         w_max_next;
  logic                  w_overflow_next;
  logic                  w_underflow_next;
  logic                  w_we;
  logic [AW-1:0]         w_waddr;
  logic [CW-1:0]         w_top_idx;
  logic [CW-1:0]         w_second_idx;
  logic [DATA_WIDTH-1:0] w_rdata_top;
  logic [DATA_WIDTH-1:0] w_rdata_second;
  logic [DATA_WIDTH-1:0] w_top_next;
  logic [DATA_WIDTH-1:0] w_second_next;

  always_comb begin
    if (clear) begin
      w_op = OP_CLEAR;
    end else if (push && pop) begin
      w_op = OP_REPLACE;
    end else if (push) begin
      w_op = OP_PUSH;
    end else if (pop) begin
      w_op = OP_POP;
    end else begin
      w_op = OP_IDLE;
    end
  end

  always_comb begin
    w_count_next     = r_count;
    w_overflow_next  = r_overflow;
    w_underflow_next = r_underflow;
    w_we             = 1'b0;
    w_waddr          = r_count[AW-1:0];
    case (w_op)
      OP_CLEAR: begin
        w_count_next     = '0;
        w_overflow_next  = 1'b0;
        w_underflow_next = 1'b0;
      end
      OP_PUSH: begin
        if (r_full) begin
          w_overflow_next = 1'b1;
        end else begin
          w_we         = 1'b1;
          w_count_next = r_count + CW'(1);
        end
      end
      OP_POP: begin
        if (r_empty) begin
          w_underflow_next = 1'b1;
        end else begin
          w_count_next = r_count - CW'(1);
        end
      end
      OP_REPLACE: begin
        // On an empty stack this acts as a plain push. Otherwise it overwrites the top in place.
        w_we = 1'b1;
        if (r_empty) begin
          w_count_next = r_count + CW'(1);
        end else begin
          w_waddr = AW'(r_count - CW'(1));
        end
      end
      default: begin
      end
    endcase
  end

  assign w_max_next   = (w_count_next > r_max_count) ? w_count_next : r_max_count;
  assign w_top_idx    = w_count_next - CW'(1);
  assign w_second_idx = w_count_next - CW'(2);

  stack_regfile #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_regfile (
    .clk      (clk),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (push_data),
    .i_raddr0 (w_top_idx[AW-1:0]),
    .i_raddr1 (w_second_idx[AW-1:0]),
    .o_rdata0 (w_rdata_top),
    .o_rdata1 (w_rdata_second)
  );

  // The views are read at post-update indices. A same-cycle write to that slot must win.
  always_comb begin
    w_top_next    = ZERO_FRAME;
    w_second_next = ZERO_FRAME;
    if (w_count_next != '0) begin
      w_top_next = (w_we && (w_waddr == w_top_idx[AW-1:0])) ? push_data : w_rdata_top;
    end
    if (w_count_next >= CW'(2)) begin
      w_second_next = (w_we && (w_waddr == w_second_idx[AW-1:0])) ? push_data : w_rdata_second;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_max_count <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_top       <= ZERO_FRAME;
      r_second    <= ZERO_FRAME;
    end else begin
      r_count     <= w_count_next;
      r_max_count <= w_max_next;
      r_empty     <= (w_count_next == '0);
      r_full      <= (w_count_next == DEPTH_C);
      r_overflow  <= w_overflow_next;
      r_underflow <= w_underflow_next;
      r_top       <= w_top_next;
      r_second    <= w_second_next;
    end
  end

  assign top_data    = r_top;
  assign second_data = r_second;
  assign empty       = r_empty;
  assign full        = r_full;
  assign count       = r_count;
  assign max_count   = r_max_count;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_frame_stack.sv
// Directed and randomised checks of frame_stack at DEPTH=20, DATA_WIDTH=128.
module tb_frame_stack;

  localparam int DEPTH = 20;
  localparam int DW    = 128;
  localparam int CW    = 5;

  logic          clk;
  logic          reset;
  logic          push;
  logic          pop;
  logic          clear;
  logic [DW-1:0] push_data;
  logic [DW-1:0] top_data;
  logic [DW-1:0] second_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic [CW-1:0] max_count;
  logic          overflow;
  logic          underflow;

  int checks   = 0;
  int failures = 0;

  frame_stack #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .clear       (clear),
    .push_data   (push_data),
    .top_data    (top_data),
    .second_data (second_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .max_count   (max_count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction: inputs are held across one rising edge, and outputs are sampled 1 ns later.
  task automatic do_cycle(input logic r, input logic c, input logic p, input logic q,
                          input logic [DW-1:0] d);
    reset = r; clear = c; push = p; pop = q; push_data = d;
    @(posedge clk);
    #1;
    reset = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0;
    $display("txn rst=%0b clr=%0b push=%0b pop=%0b data=%0h -> count=%0d max=%0d top=%0h second=%0h ovf=%0b udf=%0b",
             r, c, p, q, d, count, max_count, top_data, second_data, overflow, underflow);
  endtask

  task automatic test_reset();
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (count !== 5'd0 || max_count !== 5'd0) begin
      failures++;
      $display("FAIL reset_counts count=%0d max=%0d expected 0/0", count, max_count);
    end
    checks++;
    if ({empty, full, overflow, underflow} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags e/f/o/u=%b expected 1000", {empty, full, overflow, underflow});
    end
    checks++;
    if (top_data !== '0 || second_data !== '0) begin
      failures++;
      $display("FAIL reset_data top=%0h second=%0h expected 0/0", top_data, second_data);
    end
  endtask

  task automatic test_push_seq();
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 128'hA);
    checks++;
    if (top_data !== 128'hA || second_data !== '0 || empty !== 1'b0) begin
      failures++;
      $display("FAIL push_a top=%0h second=%0h empty=%0b expected A/0/0", top_data, second_data, empty);
    end
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 128'hB);
    checks++;
    if (top_data !== 128'hB || second_data !== 128'hA) begin
      failures++;
      $display("FAIL push_b top=%0h second=%0h expected B/A", top_data, second_data);
    end
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 128'hC);
    checks++;
    if (top_data !== 128'hC || second_data !== 128'hB || count !== 5'd3 || max_count !== 5'd3) begin
      failures++;
      $display("FAIL push_c top=%0h second=%0h count=%0d max=%0d expected C/B/3/3",
               top_data, second_data, count, max_count);
    end
  endtask

  // This test starts from the three frames left by test_push_seq.
  task automatic test_overflow_clear();
    for (int i = 0; i < 17; i++) begin
      do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 128'h10 + DW'(i));
    end
    checks++;
    if (full !== 1'b1 || count !== 5'd20 || top_data !== 128'h20 || second_data !== 128'h1F) begin
      failures++;
      $display("FAIL fill full=%0b count=%0d top=%0h second=%0h expected 1/20/20/1f",
               full, count, top_data, second_data);
    end
    do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 128'h77);
    checks++;
    if (top_data !== 128'h77 || second_data !== 128'h1F || count !== 5'd20 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL replace_full top=%0h second=%0h count=%0d ovf=%0b expected 77/1f/20/0",
               top_data, second_data, count, overflow);
    end
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 128'hFF);
    checks++;
    if (full !== 1'b1 || count !== 5'd20 || top_data !== 128'h77 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow full=%0b count=%0d top=%0h ovf=%0b expected 1/20/77/1",
               full, count, top_data, overflow);
    end
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 128'h55);
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || max_count !== 5'd20 || top_data !== '0) begin
      failures++;
      $display("FAIL clear count=%0d empty=%0b ovf=%0b max=%0d top=%0h expected 0/1/0/20/0",
               count, empty, overflow, max_count, top_data);
    end
  endtask

  task automatic test_underflow();
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    checks++;
    if (underflow !== 1'b1 || count !== 5'd0 || empty !== 1'b1 || top_data !== '0) begin
      failures++;
      $display("FAIL underflow udf=%0b count=%0d empty=%0b top=%0h expected 1/0/1/0",
               underflow, count, empty, top_data);
    end
    do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 128'h5);
    checks++;
    if (count !== 5'd1 || top_data !== 128'h5 || second_data !== '0 ||
        underflow !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL pushpop_empty count=%0d top=%0h second=%0h udf=%0b ovf=%0b expected 1/5/0/1/0",
               count, top_data, second_data, underflow, overflow);
    end
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (underflow !== 1'b0 || count !== 5'd0) begin
      failures++;
      $display("FAIL clear_udf udf=%0b count=%0d expected 0/0", underflow, count);
    end
  endtask

  task automatic test_replace_pops();
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 128'h1);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 128'h2);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 128'h3);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 128'h9);
    checks++;
    if (top_data !== 128'h9 || second_data !== 128'h2 || count !== 5'd3) begin
      failures++;
      $display("FAIL replace top=%0h second=%0h count=%0d expected 9/2/3", top_data, second_data, count);
    end
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    checks++;
    if (top_data !== 128'h2 || second_data !== 128'h1 || count !== 5'd2) begin
      failures++;
      $display("FAIL pop1 top=%0h second=%0h count=%0d expected 2/1/2", top_data, second_data, count);
    end
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    checks++;
    if (top_data !== 128'h1 || second_data !== '0 || count !== 5'd1) begin
      failures++;
      $display("FAIL pop2 top=%0h second=%0h count=%0d expected 1/0/1", top_data, second_data, count);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    logic [DW-1:0] d;
    logic [DW-1:0] exp_top;
    logic [DW-1:0] exp_second;
    int            exp_max;
    logic          exp_ovf;
    logic          exp_udf;
    logic          r, c, p, o;
    // The run begins from a reset so that the model and the DUT start from the same state.
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    exp_max = 0; exp_ovf = 1'b0; exp_udf = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      r = (cyc == 100);
      c = ($urandom_range(0, 31) == 0);
      p = ($urandom_range(0, 99) < 55);
      o = ($urandom_range(0, 99) < 45);
      d = {$urandom, $urandom, $urandom, $urandom};
      do_cycle(r, c, p, o, d);
      if (r) begin
        q.delete(); exp_max = 0; exp_ovf = 1'b0; exp_udf = 1'b0;
      end else if (c) begin
        q.delete(); exp_ovf = 1'b0; exp_udf = 1'b0;
      end else if (p && o) begin
        if (q.size() == 0) q.push_back(d);
        else q[q.size()-1] = d;
      end else if (p) begin
        if (q.size() < DEPTH) q.push_back(d);
        else exp_ovf = 1'b1;
      end else if (o) begin
        if (q.size() > 0) void'(q.pop_back());
        else exp_udf = 1'b1;
      end
      if (q.size() > exp_max) exp_max = q.size();
      exp_top    = (q.size() >= 1) ? q[q.size()-1] : '0;
      exp_second = (q.size() >= 2) ? q[q.size()-2] : '0;
      checks++;
      if (count !== CW'(q.size()) || max_count !== CW'(exp_max) ||
          empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
          overflow !== exp_ovf || underflow !== exp_udf ||
          top_data !== exp_top || second_data !== exp_second) begin
        failures++;
        $display("FAIL random_c%0d got cnt=%0d max=%0d e=%0b f=%0b o=%0b u=%0b top=%0h sec=%0h exp cnt=%0d max=%0d o=%0b u=%0b top=%0h sec=%0h",
                 cyc, count, max_count, empty, full, overflow, underflow, top_data, second_data,
                 q.size(), exp_max, exp_ovf, exp_udf, exp_top, exp_second);
      end
      if (r) begin
        checks++;
        if (count !== 5'd0 || max_count !== 5'd0 || {empty, full, overflow, underflow} !== 4'b1000 ||
            top_data !== '0 || second_data !== '0) begin
          failures++;
          $display("FAIL midreset count=%0d max=%0d e/f/o/u=%b top=%0h second=%0h expected all reset values",
                   count, max_count, {empty, full, overflow, underflow}, top_data, second_data);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
    test_reset();
    test_push_seq();
    test_overflow_clear();
    test_underflow();
    test_replace_pops();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_stack.md
# frame_stack

Parametrised LIFO of fixed-width frames, the general-purpose successor to the per-solver field stack. It stores opaque packed frames (callers concatenate their fields into `DATA_WIDTH`) and adds several features: push+pop in one cycle as replace-top, a registered view of the top two frames, a flush, sticky overflow/underflow flags, and an occupancy high-water mark. It sits beside the depth-first search controllers and holds suspended recursion frames.

## Interface
- `DEPTH`, 20: maximum stored frames, ≥2.
- `DATA_WIDTH`, 128: frame width in bits, ≥1.
- `CW`, `$clog2(DEPTH+1)`: count width. Derived; never overridden.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `push`  in  1: one-cycle request to push `push_data`.
- `pop`  in  1: one-cycle request to pop the top frame.
- `clear`  in  1: flushes all frames.
- `push_data`  in  DATA_WIDTH: frame to push or replace with.
- `top_data`  out  DATA_WIDTH: frame at count-1; 0 when empty.
- `second_data`  out  DATA_WIDTH: frame at count-2; 0 when count<2.
- `empty`  out  1: count==0.
- `full`  out  1: count==DEPTH.
- `count`  out  CW: current number of frames.
- `max_count`  out  CW: highest count reached since reset.
- `overflow`  out  1: sticky; set by a dropped push.
- `underflow`  out  1: sticky; set by an ignored pop.

## Operation
- Reset values: count=0, max_count=0, empty=1, full=0, top_data=0, second_data=0, overflow=0, underflow=0. Memory contents are not reset.
- Priority per cycle is reset > clear > push/pop.
- Clear sets count=0 and clears overflow/underflow. It does not clear max_count. Any push/pop in the same cycle is discarded.
- push only, not full: mem[count]←push_data, count+1.
- push only, full: no change, overflow←1.
- pop only, not empty: count−1. The vacated entry is not scrubbed.
- pop only, empty: no change, underflow←1.
- push+pop, not empty: replace top, so mem[count-1]←push_data and count is unchanged. Never flags, even when full.
- push+pop, empty: treated as a plain push, with no underflow.
- max_count←max(max_count, next count) every cycle.
- Outputs are registered and derived from the post-update state, including top_data/second_data.
- No combinational path from any input to any output.

## Timing
- All outputs reflect an operation on the first rising edge after it, i.e. latency 1.
- Back-to-back operations every cycle are supported with no bubbles.
- A pop followed on the next cycle by a pop sees the updated top immediately. The frame that was second becomes top_data one cycle after the first pop.
- After a replace, top_data=new frame and second_data is unchanged on the next cycle.
- Reset asserted mid-sequence takes effect on that edge. All outputs return to reset values and in-flight operations are lost.
- A write to mem[i] and a read for top_data/second_data at the same index in the same cycle must return the written data (write-first bypass).

## Structure
- Package `stack_pkg`: function `count_width(depth)` and a typedef-free localparam helper for zero frames. Solver packages define their frame field layouts there as pack/unpack functions, so `frame_stack` stays field-agnostic.
- Sub-module `stack_regfile`: DEPTH×DATA_WIDTH register array with one write port and two combinational read ports (count-1, count-2). `frame_stack` holds count, flags, the bypass and the output registers.
- Synthesise the register file as distributed RAM or flops; no block-RAM read latency is permitted.

## Test plan
- Reset, then push 0xA, 0xB, 0xC on consecutive cycles → next cycles show top/second = A/0, B/A, C/B; count 3; max_count 3.
- Fill to DEPTH=20, then one more push of 0xFF → full=1, count stays 20, top unchanged, overflow=1. A subsequent clear → count 0, empty=1, overflow=0, max_count=20.
- From empty, pop → underflow=1, outputs unchanged. Push 0x5 with pop in the same cycle → count 1, top 0x5, no flag change.
- With stack {1,2,3}, push+pop with 0x9 → top 9, second 2, count 3. Then two consecutive pops → top 2 after the first, top 1 with second 0 after the second.
- Pushes interleaved with pops every cycle for 200 random cycles → outputs match a reference model each cycle. Assert reset at cycle 100 and check all reset values on the next cycle.
